// File: rtl/transaccion_pkg.sv
// Shared definitions for the transaction layer: default lane/counter sizing
// and the reporting FSM state encoding.
package transaccion_pkg;

  localparam int DEFAULT_NUM_LANES = 4;
  localparam int DEFAULT_CNT_WIDTH = 5;

  typedef enum logic {
    COUNTING  = 1'b0,
    REPORTING = 1'b1
  } state_e;

endpackage

// File: rtl/pop_lane_counter.sv
// Saturating pop tally for one output FIFO lane; init clears it synchronously
// and wins over a same-cycle increment.
module pop_lane_counter
  import transaccion_pkg::*;
#(
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (init) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pop_word_counter.sv
// Per-lane pop tallies for the output FIFOs, with a one-cycle-latency tally
// query that is only answered while the transaction FSM reports idle.
module pop_word_counter
  import transaccion_pkg::*;
#(
  parameter int NUM_LANES = DEFAULT_NUM_LANES,
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH,
  localparam int IDX_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic                 idle,
  input  logic [NUM_LANES-1:0] pop,
  input  logic [NUM_LANES-1:0] empty,
  input  logic                 req,
  input  logic [IDX_W-1:0]     idx,
  output logic [CNT_WIDTH-1:0] data,
  output logic                 valid,
  output state_e               state
);

  logic [CNT_WIDTH-1:0] counts [NUM_LANES];
  logic [CNT_WIDTH-1:0] sel_count;
  logic                 report;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    pop_lane_counter #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .init  (init),
      .inc   (pop[i] && !empty[i]),
      .count (counts[i])
    );
  end

  // Lanes with no matching index (non power-of-two lane counts) read as 0.
  always_comb begin
    sel_count = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (idx == IDX_W'(i)) sel_count = counts[i];
    end
  end

  // Query protocol: req/idx are sampled each edge with no backpressure; when
  // accepted, valid is high for exactly the following cycle with the tally
  // held before that edge. Unaccepted requests are dropped, never queued.
  assign report = req && idle && (state == REPORTING);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= COUNTING;
      data  <= '0;
      valid <= 1'b0;
    end else begin
      case (state)
        COUNTING:  if (idle && !init) state <= REPORTING;
        REPORTING: if (!idle || init) state <= COUNTING;
      endcase
      valid <= report;
      if (report) data <= sel_count;
    end
  end

endmodule

// File: tb/tb_pop_word_counter.sv
// Self-checking bench for pop_word_counter: directed scenarios plus a random
// phase, all outputs scored against an independent behavioural model.
module tb_pop_word_counter;
  import transaccion_pkg::*;

  localparam int NL = DEFAULT_NUM_LANES;
  localparam int CW = DEFAULT_CNT_WIDTH;
  localparam logic [CW-1:0] CNT_MAX = 5'd31;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          init  = 1'b0;
  logic          idle  = 1'b0;
  logic          req   = 1'b0;
  logic [NL-1:0] pop   = '0;
  logic [NL-1:0] empty = '0;
  logic [1:0]    idx   = '0;
  logic [CW-1:0] data;
  logic          valid;
  state_e        state;

  int n_checks = 0;
  int n_fail   = 0;

  // expected {state, valid, data} after each clock edge
  logic [CW+1:0] exp_q[$];
  logic [CW-1:0] m_cnt [NL];
  logic          m_state;
  logic [CW-1:0] m_data;

  pop_word_counter dut (
    .clk   (clk),
    .reset (reset),
    .init  (init),
    .idle  (idle),
    .pop   (pop),
    .empty (empty),
    .req   (req),
    .idx   (idx),
    .data  (data),
    .valid (valid),
    .state (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model, evaluated on the same edges as the DUT
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NL; i++) m_cnt[i] <= '0;
      m_state <= 1'b0;
      m_data  <= '0;
      exp_q.delete();
    end else begin
      if (req && m_state && idle) begin
        exp_q.push_back({idle && !init, 1'b1, m_cnt[idx]});
        m_data <= m_cnt[idx];
      end else begin
        exp_q.push_back({idle && !init, 1'b0, m_data});
      end
      m_state <= idle && !init;
      for (int i = 0; i < NL; i++) begin
        if (init) m_cnt[i] <= '0;
        else if (pop[i] && !empty[i] && (m_cnt[i] != CNT_MAX)) m_cnt[i] <= m_cnt[i] + 1'b1;
      end
    end
  end

  // scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [CW+1:0] e;
      e = exp_q.pop_front();
      check("scoreboard", {state, valid, data}, e);
    end
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic enter_report();
    req  = 1'b0;
    init = 1'b0;
    pop  = '0;
    idle = 1'b1;
    tick();
  endtask

  task automatic query(input logic [1:0] lane, input logic [CW-1:0] want);
    idx = lane;
    req = 1'b1;
    tick();
    check("query_valid", valid, 1);
    check("query_data", data, want);
  endtask

  initial begin
    #1 reset = 1'b1;
    #2;
    check("reset_valid", valid, 0);
    check("reset_data", data, 0);
    check("reset_state", state, COUNTING);
    #9 reset = 1'b0;

    // reset then init
    init = 1'b1; idle = 1'b1; req = 1'b1; idx = 2'd0;
    tick();
    check("init_valid", valid, 0);
    check("init_state", state, COUNTING);
    init = 1'b0;
    tick();
    check("enter_state", state, REPORTING);
    for (int i = 0; i < NL; i++) query(i[1:0], 5'd0);

    // counting: 5 pops lane0, 6 lane1, 1 lane3
    req = 1'b0; idle = 1'b0; empty = '0;
    for (int c = 0; c < 6; c++) begin
      pop = {c < 1, 1'b0, c < 6, c < 5};
      tick();
    end
    enter_report();
    query(2'd0, 5'd5);
    query(2'd1, 5'd6);
    query(2'd2, 5'd0);
    query(2'd3, 5'd1);

    // pops on an empty FIFO are ignored
    req = 1'b0; idle = 1'b0;
    pop = 4'b0100; empty = 4'b0100;
    repeat (4) tick();
    empty = '0;
    enter_report();
    query(2'd2, 5'd0);

    // saturation
    req = 1'b0; idle = 1'b0; pop = 4'b0010;
    repeat (40) tick();
    enter_report();
    query(2'd1, CNT_MAX);
    req = 1'b0; idle = 1'b0; pop = 4'b0010;
    tick();
    enter_report();
    query(2'd1, CNT_MAX);

    // gating by idle / state
    query(2'd0, 5'd5);
    idle = 1'b0; req = 1'b1; idx = 2'd1;
    tick();
    check("gated_valid", valid, 0);
    check("gated_data", data, 5);
    idle = 1'b1;
    tick();
    check("rise_valid", valid, 0);
    check("rise_state", state, REPORTING);
    tick();
    check("resume_valid", valid, 1);
    check("resume_data", data, CNT_MAX);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      pop   = 4'($urandom_range(0, 15));
      empty = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      idle  = ($urandom_range(0, 3) != 0);
      req   = 1'($urandom_range(0, 1));
      idx   = 2'($urandom_range(0, 3));
      init  = ($urandom_range(0, 60) == 0);
      tick();
    end

    // asynchronous reset while a report is showing
    enter_report();
    idx = 2'd0; req = 1'b1;
    tick();
    check("pre_reset_valid", valid, 1);
    #1 reset = 1'b1;
    #1;
    check("async_valid", valid, 0);
    check("async_data", data, 0);
    check("async_state", state, COUNTING);
    #1 reset = 1'b0;
    pop = '0; empty = '0; init = 1'b0;
    enter_report();
    for (int i = 0; i < NL; i++) query(i[1:0], 5'd0);

    req = 1'b0;
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
